turbo_iter_ctrl: RTL and testbench
==================================

Name: turbo_iter_ctrl

Overview:
- Iteration controller for the turbo decoder. Time-shares one SISO decoder between the two constituent half-iterations.
- Per half-iteration it:
  - loads systematic, parity and a-priori (extrinsic) data into the SISO;
  - waits for the SISO to finish;
  - derives new extrinsic values;
  - applies the fixed interleaver or deinterleaver.
- After MAX_ITER full iterations it emits 5 hard-decision bits.

Parameters:
- MAX_ITER, 4, full iterations per block (1..15).
- TIMEOUT, 64, max cycles to wait for siso_finish_i before aborting.
- N_SYM, 7, symbols per block (5 info + 2 tail); fixed, not overridable.
- EXT_W, 12, bits per extrinsic/LLR field.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- sys_i  in  28  systematic soft values, 7 x 4-bit signed; symbol k at [27-4k:24-4k].
- par1_i  in  28  parity, encoder 1, same packing.
- par2_i  in  28  parity, encoder 2 (interleaved order), same packing.
- busy_o  out  1  high from accepted start until done_o/err_o.
- done_o  out  1  one-cycle pulse; bits_o valid in that cycle.
- err_o  out  1  one-cycle pulse on SISO timeout.
- bits_o  out  5  decoded bits; bits_o[4-k] = decision on symbol k; held until next done_o.
- iter_o  out  4  current iteration number (0-based).
- siso_read_en_o  out  1  one-cycle load strobe to the SISO.
- siso_sys_o  out  28  systematic values to the SISO.
- siso_enc_o  out  28  parity values to the SISO.
- siso_ext_o  out  84  a-priori values to the SISO, 7 x 12-bit; symbol k at [83-12k:72-12k].
- siso_llr_i  in  84  SISO LLR output, same packing.
- siso_finish_i  in  1  SISO completion pulse; siso_llr_i valid in that cycle.

Behaviour:
- Reset: all outputs 0, state IDLE, internal ext/LLR registers 0.
- Interleaver: pi(j) = (3j) mod 7, i.e. 0,3,6,2,5,1,4.
  - Interleave: out[j] = in[pi(j)].
  - Deinterleave: out[pi(j)] = in[j].
- States:
  - IDLE: if start_i, capture sys/par1/par2, clear ext_a to 0, iter=0, busy_o=1 -> H1_ISSUE.
  - H1_ISSUE: drive sys, par1, ext_a; siso_read_en_o=1 for this cycle only -> H1_WAIT.
  - H1_WAIT: buses held stable; on siso_finish_i -> H1_EXT; if wait count reaches TIMEOUT -> ABORT.
  - H1_EXT: ext_b[k] = sat(LLR[k] - sext(sys[k]) - ext_a[k]) -> H2_ISSUE.
  - H2_ISSUE: drive interleave(sys), par2, interleave(ext_b); read_en 1 cycle -> H2_WAIT.
  - H2_WAIT: same as H1_WAIT -> H2_EXT or ABORT.
  - H2_EXT:
    - e[j] = sat(LLR[j] - sext(sys_int[j]) - ext_b_int[j]); ext_a = deinterleave(e); L2 = deinterleave(LLR).
    - If iter == MAX_ITER-1 -> DECIDE; else iter+1 -> H1_ISSUE.
  - DECIDE: bits_o[4-k] = (L2[k] > 0) for k=0..4; done_o=1; busy_o=0 -> IDLE.
  - ABORT: err_o=1, busy_o=0, bits_o unchanged -> IDLE.
- Arithmetic:
  - sext = sign-extend 4-bit to EXT_W.
  - Difference computed at EXT_W+2 bits, saturated to [-2048, 2047].
  - L2[k] = 0 decides bit 0.
- Timeout counter: cleared in each ISSUE state, increments each WAIT cycle; abort when it equals TIMEOUT.
- siso_finish_i outside WAIT states is ignored.
- start_i while busy is ignored; no queuing.
- Reset mid-operation: immediate return to IDLE, all outputs 0; the next start runs a fresh decode.
- Latency: 2 + MAX_ITER*(2*(siso latency + 2)) cycles from start to done_o.

Test Plan:
- Mock SISO with 5-cycle finish returning LLR = 4*sys; sys_i=28'h9999999, par1/par2 = 28'h9999999 -> done_o after 4 iterations, bits_o=5'b00000, iter_o=3 at done.
- Same mock, sys_i=28'h7777777 -> bits_o=5'b11111; siso_read_en_o pulses exactly 8 times, each exactly 1 cycle wide.
- Interleave check: sys_i=28'h0123456 -> second load has siso_sys_o=28'h0362514.
- Saturation: mock LLR=2047 all fields, sys=-8, ext_a=0 -> ext_b fields = 2047; LLR=-2048, sys=7 -> -2048.
- Mock never finishes -> err_o pulse at cycle TIMEOUT after first read_en, busy_o drops, bits_o unchanged; a following start decodes normally.
- reset_n_i low during H2_WAIT of iteration 1 -> all outputs 0 immediately; start_i ignored during busy (second pulse mid-decode produces only one done_o).

Source files
------------

// File: rtl/turbo_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : turbo_iter_ctrl
// Purpose  : Iteration controller for a 7-symbol turbo decoder. Time-shares
//            one SISO between the two constituent half-iterations, derives
//            extrinsic values, applies the pi(j) = 3j mod 7 interleaver and
//            emits 5 hard decisions after MAX_ITER full iterations.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, reset_n_i       : clock (rising edge), async active-low reset
//   start_i                : start request, sampled only while idle
//   sys_i/par1_i/par2_i    : 7 x 4-bit signed soft inputs, symbol k at MSB end
//   busy_o/done_o/err_o    : status; done_o/err_o are one-cycle pulses
//   bits_o                 : decisions, bits_o[4-k] for symbol k
//   iter_o                 : current iteration (0-based)
//   siso_read_en_o         : one-cycle load strobe to the SISO
//   siso_sys_o/enc_o/ext_o : operands presented to the SISO
//   siso_llr_i/finish_i    : SISO result and its completion pulse
// ============================================================================
module turbo_iter_ctrl #(
    parameter int   MAX_ITER = 4,
    parameter int   TIMEOUT  = 64,
    parameter int   EXT_W    = 12,
    localparam int  N_SYM    = 7
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [4*N_SYM-1:0]     sys_i,
    input  logic [4*N_SYM-1:0]     par1_i,
    input  logic [4*N_SYM-1:0]     par2_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [4:0]             bits_o,
    output logic [3:0]             iter_o,
    output logic                   siso_read_en_o,
    output logic [4*N_SYM-1:0]     siso_sys_o,
    output logic [4*N_SYM-1:0]     siso_enc_o,
    output logic [EXT_W*N_SYM-1:0] siso_ext_o,
    input  logic [EXT_W*N_SYM-1:0] siso_llr_i,
    input  logic                   siso_finish_i
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic signed [EXT_W+1:0] c_sat_max = {3'b000, {(EXT_W-1){1'b1}}};
    localparam logic signed [EXT_W+1:0] c_sat_min = {3'b111, {(EXT_W-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_H1_ISSUE, S_H1_WAIT, S_H1_EXT,
        S_H2_ISSUE, S_H2_WAIT, S_H2_EXT, S_DECIDE, S_ABORT
    } state_t;

    state_t r_state, w_state_next;

    logic [4*N_SYM-1:0]      r_sys, r_par1, r_par2;
    logic signed [EXT_W-1:0] r_ext_a [N_SYM];
    logic signed [EXT_W-1:0] r_ext_b [N_SYM];
    logic signed [EXT_W-1:0] r_llr   [N_SYM];
    logic [3:0]              r_iter;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [4:0]              r_bits;
    logic [4:0]              w_bits;
    logic                    w_last;
    logic                    w_timeout;

    // Interleaver permutation and its inverse (3 * 5 = 15 = 1 mod 7).
    function automatic int f_pi(input int j);
        return (3 * j) % N_SYM;
    endfunction

    function automatic int f_pinv(input int k);
        return (5 * k) % N_SYM;
    endfunction

    function automatic logic signed [3:0] f_sym(input logic [4*N_SYM-1:0] bus, input int k);
        return bus[4*(N_SYM-k)-1 -: 4];
    endfunction

    // Extrinsic = sat(llr - sext(sys) - apriori), evaluated two bits wider
    // than the field so the worst-case difference cannot wrap.
    function automatic logic signed [EXT_W-1:0] f_ext(
        input logic signed [EXT_W-1:0] llr,
        input logic signed [3:0]       s,
        input logic signed [EXT_W-1:0] a
    );
        logic signed [EXT_W+1:0] d;
        d = {{2{llr[EXT_W-1]}}, llr} - {{(EXT_W-2){s[3]}}, s} - {{2{a[EXT_W-1]}}, a};
        if (d > c_sat_max)
            d = c_sat_max;
        else if (d < c_sat_min)
            d = c_sat_min;
        return d[EXT_W-1:0];
    endfunction

    assign w_last    = (r_iter == 4'(MAX_ITER - 1));
    // r_cnt is zero in the first wait cycle, so the abort state (err_o)
    // lands exactly TIMEOUT cycles after the read strobe.
    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT - 2));

    // Decisions on the deinterleaved LLRs: L2[k] = LLR[pinv(k)]; zero decides 0.
    always_comb begin
        w_bits = '0;
        for (int k = 0; k < 5; k++)
            w_bits[4-k] = (r_llr[f_pinv(k)] > 0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        busy_o         = 1'b1;
        done_o         = 1'b0;
        err_o          = 1'b0;
        siso_read_en_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i)
                    w_state_next = S_H1_ISSUE;
            end
            S_H1_ISSUE: begin
                siso_read_en_o = 1'b1;
                w_state_next   = S_H1_WAIT;
            end
            S_H1_WAIT: begin
                if (siso_finish_i)
                    w_state_next = S_H1_EXT;
                else if (w_timeout)
                    w_state_next = S_ABORT;
            end
            S_H1_EXT:   w_state_next = S_H2_ISSUE;
            S_H2_ISSUE: begin
                siso_read_en_o = 1'b1;
                w_state_next   = S_H2_WAIT;
            end
            S_H2_WAIT: begin
                if (siso_finish_i)
                    w_state_next = S_H2_EXT;
                else if (w_timeout)
                    w_state_next = S_ABORT;
            end
            S_H2_EXT:   w_state_next = w_last ? S_DECIDE : S_H1_ISSUE;
            S_DECIDE: begin
                busy_o       = 1'b0;
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            S_ABORT: begin
                busy_o       = 1'b0;
                err_o        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                busy_o       = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // SISO operand buses: held for the whole issue/wait window of each half.
    always_comb begin
        siso_sys_o = '0;
        siso_enc_o = '0;
        siso_ext_o = '0;
        if (r_state == S_H1_ISSUE || r_state == S_H1_WAIT) begin
            siso_sys_o = r_sys;
            siso_enc_o = r_par1;
            for (int k = 0; k < N_SYM; k++)
                siso_ext_o[EXT_W*(N_SYM-k)-1 -: EXT_W] = r_ext_a[k];
        end else if (r_state == S_H2_ISSUE || r_state == S_H2_WAIT) begin
            siso_enc_o = r_par2;    // already in interleaved order
            for (int j = 0; j < N_SYM; j++) begin
                siso_sys_o[4*(N_SYM-j)-1 -: 4]         = f_sym(r_sys, f_pi(j));
                siso_ext_o[EXT_W*(N_SYM-j)-1 -: EXT_W] = r_ext_b[f_pi(j)];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sys  <= '0;
            r_par1 <= '0;
            r_par2 <= '0;
            r_iter <= '0;
            r_cnt  <= '0;
            r_bits <= '0;
            for (int k = 0; k < N_SYM; k++) begin
                r_ext_a[k] <= '0;
                r_ext_b[k] <= '0;
                r_llr[k]   <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_sys  <= sys_i;
                        r_par1 <= par1_i;
                        r_par2 <= par2_i;
                        r_iter <= '0;
                        for (int k = 0; k < N_SYM; k++)
                            r_ext_a[k] <= '0;
                    end
                end
                S_H1_ISSUE, S_H2_ISSUE: r_cnt <= '0;
                S_H1_WAIT, S_H2_WAIT: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (siso_finish_i)
                        for (int k = 0; k < N_SYM; k++)
                            r_llr[k] <= siso_llr_i[EXT_W*(N_SYM-k)-1 -: EXT_W];
                end
                S_H1_EXT: begin
                    for (int k = 0; k < N_SYM; k++)
                        r_ext_b[k] <= f_ext(r_llr[k], f_sym(r_sys, k), r_ext_a[k]);
                end
                S_H2_EXT: begin
                    // LLRs arrive in interleaved order; writing to pi(j)
                    // deinterleaves the new a-priori values.
                    for (int j = 0; j < N_SYM; j++)
                        r_ext_a[f_pi(j)] <= f_ext(r_llr[j], f_sym(r_sys, f_pi(j)), r_ext_b[f_pi(j)]);
                    if (w_last)
                        r_bits <= w_bits;
                    else
                        r_iter <= r_iter + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bits_o = r_bits;
    assign iter_o = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_turbo_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_turbo_iter_ctrl
// Purpose  : Self-checking bench for turbo_iter_ctrl with a mock SISO that
//            finishes 5 cycles after each load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_turbo_iter_ctrl;

    localparam logic [27:0] P1 = 28'hABCDEF1;
    localparam logic [27:0] P2 = 28'h2468ACE;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [27:0] sys_i = '0, par1_i = '0, par2_i = '0;
    logic        busy_o, done_o, err_o, siso_read_en_o;
    logic [4:0]  bits_o;
    logic [3:0]  iter_o;
    logic [27:0] siso_sys_o, siso_enc_o;
    logic [83:0] siso_ext_o;
    logic [83:0] siso_llr_i;
    logic        siso_finish_i;

    turbo_iter_ctrl #(.MAX_ITER(4), .TIMEOUT(64), .EXT_W(12)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
        .sys_i(sys_i), .par1_i(par1_i), .par2_i(par2_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .bits_o(bits_o),
        .iter_o(iter_o), .siso_read_en_o(siso_read_en_o),
        .siso_sys_o(siso_sys_o), .siso_enc_o(siso_enc_o), .siso_ext_o(siso_ext_o),
        .siso_llr_i(siso_llr_i), .siso_finish_i(siso_finish_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- mock SISO ----------------
    // mode 0: LLR = 4*sys, 1: all +2047, 2: all -2048, 3: never finishes
    int   mock_mode = 0;
    int   m_cnt;
    logic m_pend;

    function automatic logic [83:0] mock_llr(input int mode, input logic [27:0] s);
        logic [83:0]       r;
        logic signed [3:0] f;
        logic [11:0]       v;
        r = '0;
        for (int k = 0; k < 7; k++) begin
            f = s[27-4*k -: 4];
            if (mode == 1)      v = 12'h7FF;
            else if (mode == 2) v = 12'h800;
            else                v = 12'(4 * f);
            r[83-12*k -: 12] = v;
        end
        return r;
    endfunction

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_pend        <= 1'b0;
            m_cnt         <= 0;
            siso_finish_i <= 1'b0;
            siso_llr_i    <= '0;
        end else begin
            siso_finish_i <= 1'b0;
            if (siso_read_en_o && mock_mode != 3) begin
                m_pend     <= 1'b1;
                m_cnt      <= 1;
                siso_llr_i <= mock_llr(mock_mode, siso_sys_o);
            end else if (m_pend) begin
                if (m_cnt == 4) begin
                    siso_finish_i <= 1'b1;
                    m_pend        <= 1'b0;
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- load monitor ----------------
    int          highs = 0, rises = 0, dones = 0;
    logic        prev_ren = 1'b0;
    logic [27:0] ld_sys [256];
    logic [27:0] ld_enc [256];
    logic [83:0] ld_ext [256];

    always @(negedge clk_i) begin
        if (siso_read_en_o) begin
            ld_sys[highs % 256] = siso_sys_o;
            ld_enc[highs % 256] = siso_enc_o;
            ld_ext[highs % 256] = siso_ext_o;
            highs = highs + 1;
            if (!prev_ren) rises = rises + 1;
        end
        prev_ren = siso_read_en_o;
        if (done_o) dones = dones + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          mode;
        logic [27:0] sys;
        logic [27:0] exp_sys2;
        logic [83:0] exp_ext2;
        logic [83:0] exp_ext3;
        logic [4:0]  exp_bits;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [83:0] rep7(input logic [11:0] x);
        return {7{x}};
    endfunction

    task automatic run_vec(input int idx, input bit extra);
        int   h0, r0, d0, n;
        bit   got_done, got_err;
        vec_t v;
        v = vecs[idx];
        @(posedge clk_i); #1;
        mock_mode = v.mode;
        sys_i = v.sys; par1_i = P1; par2_i = P2;
        h0 = highs; r0 = rises; d0 = dones;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        if (extra) begin
            repeat (10) @(posedge clk_i);
            #1 sys_i = 28'h9999999; start_i = 1'b1;
            @(posedge clk_i); #1 start_i = 1'b0;
        end
        got_done = 0; got_err = 0; n = 0;
        while (!got_done && !got_err && n < 300) begin
            @(negedge clk_i);
            n++;
            if (done_o)     got_done = 1;
            else if (err_o) got_err = 1;
        end
        chk($sformatf("v%0d done_seen", idx), 128'(got_done), 128'd1);
        if (got_done) begin
            chk($sformatf("v%0d bits", idx), 128'(bits_o), 128'(v.exp_bits));
            chk($sformatf("v%0d iter_at_done", idx), 128'(iter_o), 128'd3);
            chk($sformatf("v%0d busy_at_done", idx), 128'(busy_o), 128'd0);
        end
        repeat (20) @(posedge clk_i);
        chk($sformatf("v%0d read_en_cycles", idx), 128'(highs - h0), 128'd8);
        chk($sformatf("v%0d read_en_pulses", idx), 128'(rises - r0), 128'd8);
        chk($sformatf("v%0d done_count", idx), 128'(dones - d0), 128'd1);
        chk($sformatf("v%0d load1_sys", idx), 128'(ld_sys[h0 % 256]), 128'(v.sys));
        chk($sformatf("v%0d load1_enc", idx), 128'(ld_enc[h0 % 256]), 128'(P1));
        chk($sformatf("v%0d load2_sys", idx), 128'(ld_sys[(h0+1) % 256]), 128'(v.exp_sys2));
        chk($sformatf("v%0d load2_enc", idx), 128'(ld_enc[(h0+1) % 256]), 128'(P2));
        chk($sformatf("v%0d load2_ext", idx), 128'(ld_ext[(h0+1) % 256]), 128'(v.exp_ext2));
        chk($sformatf("v%0d load3_ext", idx), 128'(ld_ext[(h0+2) % 256]), 128'(v.exp_ext3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  h0, n;
        bit  early, busy_bad;

        vecs[0] = '{0, 28'h9999999, 28'h9999999, rep7(12'hFEB), '0, 5'b00000};
        vecs[1] = '{0, 28'h7777777, 28'h7777777, rep7(12'h015), '0, 5'b11111};
        vecs[2] = '{0, 28'h0123456, 28'h0362514,
                    {12'h000, 12'h009, 12'h012, 12'h006, 12'h00F, 12'h003, 12'h00C}, '0, 5'b01111};
        vecs[3] = '{0, 28'h1F2E3D4, 28'h1E42DF3,
                    {12'h003, 12'hFFA, 12'h00C, 12'h006, 12'hFF7, 12'hFFD, 12'h009}, '0, 5'b10101};
        vecs[4] = '{0, 28'h0000000, 28'h0000000, '0, '0, 5'b00000};
        vecs[5] = '{0, 28'h8181818, 28'h8188118,
                    {12'hFE8, 12'h003, 12'hFE8, 12'hFE8, 12'h003, 12'h003, 12'hFE8}, '0, 5'b01010};
        vecs[6] = '{2, 28'h7777777, 28'h7777777, rep7(12'h800), rep7(12'hFF9), 5'b00000};
        vecs[7] = '{1, 28'h8888888, 28'h8888888, rep7(12'h7FF), rep7(12'h008), 5'b11111};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset busy", 128'(busy_o), 128'd0);
        chk("reset done_err", 128'({done_o, err_o, siso_read_en_o}), 128'd0);
        chk("reset bits_iter", 128'({bits_o, iter_o}), 128'd0);
        chk("reset buses", 128'({siso_sys_o, siso_enc_o, siso_ext_o}), 128'd0);
        @(negedge clk_i) reset_n_i = 1'b1;

        for (int i = 0; i < 8; i++)
            run_vec(i, 1'b0);

        // SISO never finishes: abort exactly 64 cycles after the first strobe
        @(posedge clk_i); #1;
        mock_mode = 3; sys_i = 28'h0123456; h0 = highs;
        start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        n = 0;
        while (highs == h0 && n < 20) begin
            @(posedge clk_i);
            n++;
        end
        chk("timeout strobe_seen", 128'(highs - h0), 128'd1);
        early = 0; busy_bad = 0;
        for (int k = 1; k < 64; k++) begin
            @(negedge clk_i);
            if (err_o)   early = 1;
            if (!busy_o) busy_bad = 1;
        end
        chk("timeout no_early_err", 128'(early), 128'd0);
        chk("timeout busy_held", 128'(busy_bad), 128'd0);
        @(negedge clk_i);
        chk("timeout err_pulse", 128'(err_o), 128'd1);
        chk("timeout busy_drop", 128'(busy_o), 128'd0);
        chk("timeout done_low", 128'(done_o), 128'd0);
        chk("timeout bits_kept", 128'(bits_o), 128'(5'b11111));
        @(negedge clk_i);
        chk("timeout err_one_cycle", 128'(err_o), 128'd0);

        // Decode after abort, then a decode with a second start mid-flight
        run_vec(2, 1'b0);
        run_vec(1, 1'b1);

        // Reset during H2_WAIT of iteration 1
        @(posedge clk_i); #1;
        mock_mode = 0; sys_i = 28'h7777777; h0 = highs;
        start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        n = 0;
        while ((highs - h0) < 4 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        chk("rst_mid iter_before", 128'(iter_o), 128'd1);
        chk("rst_mid busy_before", 128'(busy_o), 128'd1);
        reset_n_i = 1'b0;
        #1;
        chk("rst_mid busy", 128'(busy_o), 128'd0);
        chk("rst_mid bits_iter", 128'({bits_o, iter_o}), 128'd0);
        chk("rst_mid buses", 128'({siso_sys_o, siso_enc_o, siso_ext_o}), 128'd0);
        chk("rst_mid pulses", 128'({done_o, err_o, siso_read_en_o}), 128'd0);
        @(negedge clk_i) reset_n_i = 1'b1;
        run_vec(3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
